// File: rtl/restador_serie.sv
// restador_serie: bit-serial N-bit subtractor, D = A - B - Bi, LSB first, one bit per clock.
// A 1-bit full-subtractor cell with a registered borrow walks the captured operands.
// The SUB path of the ALU, trading area for N cycles of latency.
//
// Ports:
//   clk    in   1  system clock, rising edge
//   rst_n  in   1  asynchronous reset, active-low
//   start  in   1  request; accepted only when no operation is running
//   A      in   N  minuend, captured on accepted start
//   B      in   N  subtrahend, captured on accepted start
//   Bi     in   1  borrow-in, captured on accepted start
//   D      out  N  difference; valid while done=1, held until next accepted start
//   Bo     out  1  borrow-out (unsigned A < B + Bi); same validity as D
//   V      out  1  signed overflow (only when RESTADOR_OVF_EN is defined)
//   busy   out  1  high while the operation is in progress
//   done   out  1  one-cycle pulse: D/Bo are final
//
// Configuration macro: RESTADOR_OVF_EN adds the signed-overflow output V.
module restador_serie #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Bi,
    output logic [N-1:0] D,
    output logic         Bo,
`ifdef RESTADOR_OVF_EN
    output logic         V,
`endif
    output logic         busy,
    output logic         done
);

    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         state;
    logic [N-1:0]   a_sr;
    logic [N-1:0]   b_sr;
    logic           br;
    logic [CW-1:0]  cnt;
    logic           d_bit_c;
    logic           br_next_c;
    logic           last_c;

`ifdef RESTADOR_OVF_EN
    logic           a_msb;
    logic           b_msb;
`endif

    // Full-subtractor cell on the current LSBs and the registered borrow
    assign d_bit_c   = a_sr[0] ^ b_sr[0] ^ br;
    assign br_next_c = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    assign last_c    = (cnt == CW'(N - 1));

    // Control FSM and datapath; DONE also accepts start so held start runs back to back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            D     <= '0;
            Bo    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef RESTADOR_OVF_EN
            V     <= 1'b0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= A;
                        b_sr  <= B;
                        br    <= Bi;
                        cnt   <= '0;
                        D     <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
`ifdef RESTADOR_OVF_EN
                        V     <= 1'b0;
                        a_msb <= A[N-1];
                        b_msb <= B[N-1];
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    D    <= {d_bit_c, D[N-1:1]};
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    br   <= br_next_c;
                    cnt  <= cnt + CW'(1);
                    if (last_c) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        Bo    <= br_next_c;
`ifdef RESTADOR_OVF_EN
                        // Final bit is the result MSB: overflow when signs differ and D flips sign of A
                        V     <= (a_msb ^ b_msb) & (d_bit_c ^ a_msb);
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
